// File: rtl/instr_field_queue.sv
// Fetch-to-decode instruction queue that presents the head entry split into MIPS fields.
// Optional INSTR_FIELD_QUEUE_EXT_IMM_EN adds sign/zero-extended imm32 outputs.
module instr_field_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [PC_W-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PC_W-1:0]  out_pc,
  output logic [5:0]       op,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic [4:0]       shamt,
  output logic [5:0]       func,
  output logic [15:0]      imm16,
  output logic [25:0]      addr26,
`ifdef INSTR_FIELD_QUEUE_EXT_IMM_EN
  output logic [31:0]      imm32_sext,
  output logic [31:0]      imm32_zext,
`endif
  output logic [CNT_W-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]     mem_instr [DEPTH];
  logic [PC_W-1:0] mem_pc    [DEPTH];

  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CNT_W-1:0] cnt;
  logic             push;
  logic             pop;
  logic [31:0]      head;

  assign in_ready  = (cnt != CNT_W'(DEPTH));
  assign out_valid = (cnt != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;
  assign count     = cnt;

  // Storage needs no reset; only the head of an occupied queue is visible.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr[wr_ptr] <= in_instr;
      mem_pc[wr_ptr]    <= in_pc;
    end
  end

  // Pointers and occupancy; flush wins over a concurrent push and pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Head word and PC gated to zero while empty.
  always_comb begin
    head   = '0;
    out_pc = '0;
    if (out_valid) begin
      head   = mem_instr[rd_ptr];
      out_pc = mem_pc[rd_ptr];
    end
  end

  assign op     = head[31:26];
  assign rs     = head[25:21];
  assign rt     = head[20:16];
  assign rd     = head[15:11];
  assign shamt  = head[10:6];
  assign func   = head[5:0];
  assign imm16  = head[15:0];
  assign addr26 = head[25:0];

`ifdef INSTR_FIELD_QUEUE_EXT_IMM_EN
  assign imm32_sext = {{16{head[15]}}, head[15:0]};
  assign imm32_zext = {16'h0000, head[15:0]};
`endif

endmodule

// File: tb/tb_instr_field_queue.sv
// Scoreboard bench for instr_field_queue: stimulus queues expected entries,
// a negedge monitor checks every head entry consumed by decode.
module tb_instr_field_queue;

  localparam int DEPTH = 4;
  localparam int PC_W  = 32;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_instr = '0;
  logic [PC_W-1:0]  in_pc = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [PC_W-1:0]  out_pc;
  logic [5:0]       op;
  logic [4:0]       rs;
  logic [4:0]       rt;
  logic [4:0]       rd;
  logic [4:0]       shamt;
  logic [5:0]       func;
  logic [15:0]      imm16;
  logic [25:0]      addr26;
  logic [CNT_W-1:0] count;
`ifdef INSTR_FIELD_QUEUE_EXT_IMM_EN
  logic [31:0]      imm32_sext;
  logic [31:0]      imm32_zext;
`endif

  instr_field_queue #(
    .DEPTH(DEPTH),
    .PC_W (PC_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .op        (op),
    .rs        (rs),
    .rt        (rt),
    .rd        (rd),
    .shamt     (shamt),
    .func      (func),
    .imm16     (imm16),
    .addr26    (addr26),
`ifdef INSTR_FIELD_QUEUE_EXT_IMM_EN
    .imm32_sext(imm32_sext),
    .imm32_zext(imm32_zext),
`endif
    .count     (count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     instr;
  } entry_t;

  entry_t sb[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [PC_W-1:0] pc, input logic [31:0] w,
                      input bit accept);
    in_valid = 1'b1;
    in_pc    = pc;
    in_instr = w;
    if (accept) sb.push_back('{pc: pc, instr: w});
    tick();
    in_valid = 1'b0;
  endtask

  // Monitor: a head entry taken by decode must match the scoreboard front.
  always @(negedge clk) begin
    if (!reset && !flush && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got pc 0x%0h expected none", out_pc);
      end else begin
        entry_t e;
        e = sb.pop_front();
        chk("mon_pc", 64'(out_pc), 64'(e.pc));
        chk("mon_fields", 64'({op, rs, rt, rd, shamt, func}), 64'(e.instr));
        chk("mon_imm16", 64'(imm16), 64'(e.instr[15:0]));
        chk("mon_addr26", 64'(addr26), 64'(e.instr[25:0]));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_pc", 64'(out_pc), 64'd0);

    // Field split on a single entry.
    push(32'h3000, 32'h012A4020, 1'b1);
    chk("fs_out_valid", 64'(out_valid), 64'd1);
    chk("fs_out_pc", 64'(out_pc), 64'h3000);
    chk("fs_op", 64'(op), 64'd0);
    chk("fs_rs", 64'(rs), 64'd9);
    chk("fs_rt", 64'(rt), 64'd10);
    chk("fs_rd", 64'(rd), 64'd8);
    chk("fs_shamt", 64'(shamt), 64'd0);
    chk("fs_func", 64'(func), 64'h20);
    chk("fs_imm16", 64'(imm16), 64'h4020);
    chk("fs_addr26", 64'(addr26), 64'h12A4020);
    chk("fs_count", 64'(count), 64'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("empty_valid", 64'(out_valid), 64'd0);
    chk("empty_op_gated", 64'(op), 64'd0);
    chk("empty_pc_gated", 64'(out_pc), 64'd0);
    chk("empty_addr26_gated", 64'(addr26), 64'd0);

`ifdef INSTR_FIELD_QUEUE_EXT_IMM_EN
    push(32'h0010, 32'h8C438004, 1'b1);
    chk("ext_sext", 64'(imm32_sext), 64'hFFFF8004);
    chk("ext_zext", 64'(imm32_zext), 64'h00008004);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("ext_sext_empty", 64'(imm32_sext), 64'd0);
    chk("ext_zext_empty", 64'(imm32_zext), 64'd0);
`endif

    // Fill to DEPTH, then offer a fifth entry that must be dropped.
    push(32'h0100, 32'h20010001, 1'b1);
    push(32'h0104, 32'h20020002, 1'b1);
    push(32'h0108, 32'h20030003, 1'b1);
    chk("fill_ready_3", 64'(in_ready), 64'd1);
    push(32'h010C, 32'h20040004, 1'b1);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("full_count", 64'(count), 64'd4);
    push(32'h0110, 32'h20050005, 1'b0);
    chk("overflow_count", 64'(count), 64'd4);
    out_ready = 1'b1;
    tick();
    chk("pop_frees_slot", 64'(in_ready), 64'd1);
    tick();
    tick();
    tick();
    out_ready = 1'b0;
    chk("drain_count", 64'(count), 64'd0);

    // Concurrent push and pop at count=2 across pointer wrap.
    push(32'h0200, 32'h00851020, 1'b1);
    push(32'h0204, 32'h00A62022, 1'b1);
    for (int i = 0; i < 10; i++) begin
      in_valid  = 1'b1;
      out_ready = 1'b1;
      in_pc     = 32'h0208 + 32'(4 * i);
      in_instr  = 32'h24000000 + 32'(i);
      sb.push_back('{pc: in_pc, instr: in_instr});
      tick();
      chk("pp_count", 64'(count), 64'd2);
    end
    in_valid = 1'b0;
    tick();
    tick();
    out_ready = 1'b0;
    chk("pp_drain_count", 64'(count), 64'd0);

    // Flush with a concurrent push and pop at count=3.
    push(32'h0300, 32'h11000001, 1'b1);
    push(32'h0304, 32'h11000002, 1'b1);
    push(32'h0308, 32'h11000003, 1'b1);
    flush     = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_pc     = 32'h030C;
    in_instr  = 32'h11000004;
    sb.delete();
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    tick();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    push(32'h0400, 32'h08000100, 1'b1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("post_flush_count", 64'(count), 64'd0);

    // Asynchronous reset with two entries queued.
    push(32'h0500, 32'h3C010001, 1'b1);
    push(32'h0504, 32'h3C020002, 1'b1);
    chk("pre_rst_count", 64'(count), 64'd2);
    #2;
    reset = 1'b1;
    sb.delete();
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    chk("arst_op", 64'(op), 64'd0);
    tick();
    reset = 1'b0;
    tick();
    push(32'h0600, 32'hAC220008, 1'b1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
